// File: rtl/alu_wide_ctrl_pkg.sv
// rtl/alu_wide_ctrl_pkg.sv - shared types and helpers for the 16-bit ALU sequencer
package alu_wide_ctrl_pkg;

   typedef enum logic [2:0] {
      W_ADD  = 3'd0,
      W_SUB  = 3'd1,
      W_AND  = 3'd2,
      W_OR   = 3'd3,
      W_XOR  = 3'd4,
      W_SHL1 = 3'd5,
      W_SHR1 = 3'd6,
      W_MOV  = 3'd7
   } wide_op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      P1   = 3'd1,
      P2   = 3'd2,
      P3   = 3'd3,
      DONE = 3'd4
   } wide_state_e;

   // Operation codes understood by the shared 8-bit ALU OP port.
   typedef enum logic [3:0] {
      KADD = 4'h0,
      KSUB = 4'h1,
      KLSH = 4'h2,
      KRSH = 4'h3,
      KAND = 4'h4,
      kor  = 4'h5,
      KXOR = 4'h6,
      KLOA = 4'h7
   } op_mne_e;

   function automatic logic is_three_pass(input wide_op_e op);
      return (op == W_ADD) || (op == W_SUB) || (op == W_SHL1) || (op == W_SHR1);
   endfunction

   // ALU code used for the two byte passes P1/P2.
   function automatic op_mne_e byte_pass_mne(input wide_op_e op);
      case (op)
         W_ADD:   return KADD;
         W_SUB:   return KSUB;
         W_AND:   return KAND;
         W_OR:    return kor;
         W_XOR:   return KXOR;
         W_SHL1:  return KLSH;
         W_SHR1:  return KRSH;
         default: return KLOA;
      endcase
   endfunction

endpackage

// File: rtl/alu_wide_ctrl_if.sv
// rtl/alu_wide_ctrl_if.sv - request/response and ALU port bundle for alu_wide_ctrl
interface alu_wide_ctrl_if;
   import alu_wide_ctrl_pkg::*;

   logic        start;
   wide_op_e    op;
   logic [15:0] a;
   logic [15:0] b;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   op_mne_e     alu_op;
   logic [7:0]  alu_out;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        carry_out;
   logic        zero;

   modport master (
      output start, op, a, b, alu_out,
      input  alu_a, alu_b, alu_op, busy, done, result, carry_out, zero
   );

   modport slave (
      input  start, op, a, b, alu_out,
      output alu_a, alu_b, alu_op, busy, done, result, carry_out, zero
   );

endinterface

// File: rtl/alu_wide_ctrl.sv
// rtl/alu_wide_ctrl.sv - sequences 16-bit ops as two or three passes over an 8-bit ALU
module alu_wide_ctrl
   import alu_wide_ctrl_pkg::*;
(
   input  logic          CLK,
   input  logic          Reset,
   alu_wide_ctrl_if.slave bus
);

   wide_state_e state_q;
   wide_op_e    op_q;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic [7:0]  p1_q;
   logic [7:0]  p2_q;
   logic        c_q;
   logic        ch_q;
   logic [15:0] result_q;
   logic        carry_q;
   logic        done_q;
   logic        busy_q;

   logic [7:0]  a_lo, a_hi, b_lo, b_hi;
   logic        p1_carry;
   logic        p2_carry;
   logic        p3_fix;

   assign a_lo = a_q[7:0];
   assign a_hi = a_q[15:8];
   assign b_lo = b_q[7:0];
   assign b_hi = b_q[15:8];

   // SHR1 walks high byte first so the bit shifted out of a_hi can enter lo[7].
   always_comb begin
      bus.alu_a  = 8'h00;
      bus.alu_b  = 8'h00;
      bus.alu_op = KAND;
      case (state_q)
         P1: begin
            bus.alu_op = byte_pass_mne(op_q);
            case (op_q)
               W_SHL1:  begin bus.alu_a = a_lo; bus.alu_b = 8'd1; end
               W_SHR1:  begin bus.alu_a = a_hi; bus.alu_b = 8'd1; end
               default: begin bus.alu_a = a_lo; bus.alu_b = b_lo; end
            endcase
         end
         P2: begin
            bus.alu_op = byte_pass_mne(op_q);
            case (op_q)
               W_SHL1:  begin bus.alu_a = a_hi; bus.alu_b = 8'd1; end
               W_SHR1:  begin bus.alu_a = a_lo; bus.alu_b = 8'd1; end
               default: begin bus.alu_a = a_hi; bus.alu_b = b_hi; end
            endcase
         end
         P3: begin
            bus.alu_a = p2_q;
            if (op_q == W_ADD || op_q == W_SUB) begin
               bus.alu_op = byte_pass_mne(op_q);
            end else begin
               bus.alu_op = kor;
            end
            if (op_q == W_SHR1) begin
               bus.alu_b = {c_q, 7'b0};
            end else begin
               bus.alu_b = {7'b0, c_q};
            end
         end
         default: ;
      endcase
   end

   // The ALU carries nothing out, so carry/borrow is recovered from operand compares.
   always_comb begin
      p1_carry = 1'b0;
      p2_carry = 1'b0;
      p3_fix   = 1'b0;
      case (op_q)
         W_ADD: begin
            p1_carry = bus.alu_out < a_lo;
            p2_carry = bus.alu_out < a_hi;
            p3_fix   = c_q & (bus.alu_out == 8'h00);
         end
         W_SUB: begin
            p1_carry = a_lo < b_lo;
            p2_carry = a_hi < b_hi;
            p3_fix   = c_q & (p2_q == 8'h00);
         end
         W_SHL1: begin
            p1_carry = a_lo[7];
            p2_carry = a_hi[7];
         end
         W_SHR1: begin
            p1_carry = a_hi[0];
            p2_carry = a_lo[0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q  <= IDLE;
         op_q     <= W_ADD;
         a_q      <= 16'h0000;
         b_q      <= 16'h0000;
         p1_q     <= 8'h00;
         p2_q     <= 8'h00;
         c_q      <= 1'b0;
         ch_q     <= 1'b0;
         result_q <= 16'h0000;
         carry_q  <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  op_q    <= bus.op;
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  busy_q  <= 1'b1;
                  state_q <= P1;
               end
            end
            P1: begin
               p1_q    <= bus.alu_out;
               c_q     <= p1_carry;
               state_q <= P2;
            end
            P2: begin
               if (is_three_pass(op_q)) begin
                  p2_q    <= bus.alu_out;
                  ch_q    <= p2_carry;
                  state_q <= P3;
               end else begin
                  result_q <= {bus.alu_out, p1_q};
                  carry_q  <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            P3: begin
               if (op_q == W_SHR1) begin
                  result_q <= {p1_q, bus.alu_out};
               end else begin
                  result_q <= {bus.alu_out, p1_q};
               end
               carry_q <= ch_q | p3_fix;
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.carry_out = carry_q;
   assign bus.zero      = (result_q == 16'h0000);

endmodule

// File: tb/tb_alu_wide_ctrl.sv
// tb/tb_alu_wide_ctrl.sv - directed vector bench for alu_wide_ctrl with an 8-bit ALU model
module tb_alu_wide_ctrl;
   import alu_wide_ctrl_pkg::*;

   logic CLK = 1'b0;
   logic Reset;

   always #5 CLK = ~CLK;

   alu_wide_ctrl_if bus();

   alu_wide_ctrl dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   // Shared 8-bit ALU as seen by the parent.
   always_comb begin
      case (bus.alu_op)
         KADD:    bus.alu_out = bus.alu_a + bus.alu_b;
         KSUB:    bus.alu_out = bus.alu_a - bus.alu_b;
         KLSH:    bus.alu_out = bus.alu_a << bus.alu_b[2:0];
         KRSH:    bus.alu_out = bus.alu_a >> bus.alu_b[2:0];
         KAND:    bus.alu_out = bus.alu_a & bus.alu_b;
         kor:     bus.alu_out = bus.alu_a | bus.alu_b;
         KXOR:    bus.alu_out = bus.alu_a ^ bus.alu_b;
         KLOA:    bus.alu_out = bus.alu_a;
         default: bus.alu_out = 8'h00;
      endcase
   end

   typedef struct {
      string       name;
      wide_op_e    op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        carry;
      int          cycles;
   } vec_t;

   localparam int NVEC = 11;
   vec_t vecs [NVEC];

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_op(input wide_op_e op, input logic [15:0] a, input logic [15:0] b,
                         output int cyc);
      @(negedge CLK);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(negedge CLK);
      bus.start = 1'b0;
      cyc = 1;
      while (!bus.done && cyc < 12) begin
         @(negedge CLK);
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      int ndone;
      int nbusy;

      vecs[0]  = '{"add_lo_carry", W_ADD,  16'h00FF, 16'h0001, 16'h0100, 1'b0, 4};
      vecs[1]  = '{"add_wrap",     W_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 4};
      vecs[2]  = '{"sub_lo_borrow",W_SUB,  16'h0100, 16'h0001, 16'h00FF, 1'b0, 4};
      vecs[3]  = '{"sub_wrap",     W_SUB,  16'h0000, 16'h0001, 16'hFFFF, 1'b1, 4};
      vecs[4]  = '{"shl1",         W_SHL1, 16'h80C0, 16'h0000, 16'h0180, 1'b1, 4};
      vecs[5]  = '{"shr1",         W_SHR1, 16'h0101, 16'h0000, 16'h0080, 1'b1, 4};
      vecs[6]  = '{"and",          W_AND,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 3};
      vecs[7]  = '{"or",           W_OR,   16'h1200, 16'h0034, 16'h1234, 1'b0, 3};
      vecs[8]  = '{"add_hi_carry", W_ADD,  16'h8000, 16'h8000, 16'h0000, 1'b1, 4};
      vecs[9]  = '{"add_plain",    W_ADD,  16'h1234, 16'h4321, 16'h5555, 1'b0, 4};
      vecs[10] = '{"mov",          W_MOV,  16'hBEEF, 16'h1111, 16'hBEEF, 1'b0, 3};

      Reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = W_ADD;
      bus.a     = 16'h0000;
      bus.b     = 16'h0000;
      repeat (3) @(negedge CLK);
      Reset = 1'b0;
      @(negedge CLK);
      check("rst_result", bus.result, 16'h0000);
      check("rst_zero", bus.zero, 1'b1);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_carry", bus.carry_out, 1'b0);
      check("rst_alu_op", bus.alu_op, KAND);
      check("rst_alu_ab", {bus.alu_a, bus.alu_b}, 16'h0000);

      for (int i = 0; i < NVEC; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
         check({vecs[i].name, "_latency"}, cyc, vecs[i].cycles);
         check({vecs[i].name, "_result"}, bus.result, vecs[i].res);
         check({vecs[i].name, "_carry"}, bus.carry_out, vecs[i].carry);
         check({vecs[i].name, "_zero"}, bus.zero, vecs[i].res == 16'h0000);
         @(negedge CLK);
         check({vecs[i].name, "_done_pulse"}, bus.done, 1'b0);
         check({vecs[i].name, "_busy_clr"}, bus.busy, 1'b0);
      end

      // XOR with stray starts in P1 and in DONE.
      @(negedge CLK);
      bus.start = 1'b1;
      bus.op    = W_XOR;
      bus.a     = 16'hA5A5;
      bus.b     = 16'h0FF0;
      @(negedge CLK);
      check("xor_busy_p1", bus.busy, 1'b1);
      bus.op    = W_ADD;
      bus.a     = 16'h1111;
      bus.b     = 16'h1111;
      @(negedge CLK);
      bus.start = 1'b0;
      check("xor_done_early", bus.done, 1'b0);
      @(negedge CLK);
      check("xor_done_c3", bus.done, 1'b1);
      check("xor_result", bus.result, 16'hAA55);
      check("xor_carry", bus.carry_out, 1'b0);
      bus.start = 1'b1;
      bus.a     = 16'hFFFF;
      bus.b     = 16'h0001;
      @(negedge CLK);
      bus.start = 1'b0;
      ndone = 0;
      nbusy = 0;
      for (int k = 0; k < 6; k++) begin
         if (bus.done) ndone++;
         if (bus.busy) nbusy++;
         @(negedge CLK);
      end
      check("stray_no_done", ndone, 0);
      check("stray_no_busy", nbusy, 0);
      check("stray_result_held", bus.result, 16'hAA55);

      // Reset during P2 of an ADD.
      bus.start = 1'b1;
      bus.op    = W_ADD;
      bus.a     = 16'h00FF;
      bus.b     = 16'h0001;
      @(negedge CLK);
      bus.start = 1'b0;
      @(negedge CLK);
      Reset = 1'b1;
      @(negedge CLK);
      Reset = 1'b0;
      check("mid_rst_busy", bus.busy, 1'b0);
      check("mid_rst_result", bus.result, 16'h0000);
      check("mid_rst_carry", bus.carry_out, 1'b0);
      check("mid_rst_zero", bus.zero, 1'b1);
      check("mid_rst_alu_op", bus.alu_op, KAND);
      ndone = 0;
      for (int k = 0; k < 6; k++) begin
         if (bus.done) ndone++;
         @(negedge CLK);
      end
      check("mid_rst_no_done", ndone, 0);

      // start while Reset is high is dropped.
      Reset     = 1'b1;
      bus.start = 1'b1;
      bus.op    = W_MOV;
      bus.a     = 16'h5A5A;
      @(negedge CLK);
      Reset     = 1'b0;
      bus.start = 1'b0;
      @(negedge CLK);
      check("rst_start_ignored", bus.busy, 1'b0);

      run_op(W_MOV, 16'h1234, 16'h0000, cyc);
      check("mov_after_rst_latency", cyc, 3);
      check("mov_after_rst_result", bus.result, 16'h1234);
      check("mov_after_rst_carry", bus.carry_out, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_wide_ctrl.md
# alu_wide_ctrl

Multi-cycle sequencer that performs 16-bit operations on the shared 8-bit combinational ALU by issuing two or three byte-wide passes. It sits between the core's control logic and the ALU instance. It drives the ALU's INPUTA/INPUTB/OP ports and captures OUT each cycle. The ALU drives SC_OUT to 0, so this block derives carry, borrow and shift-out bits itself.

## Interface
- Parameters: none (width fixed at 16/8).
- CLK  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op  in  3  wide_op_e: 0 W_ADD, 1 W_SUB, 2 W_AND, 3 W_OR, 4 W_XOR, 5 W_SHL1, 6 W_SHR1, 7 W_MOV
- a, b  in  16  operands, latched when start is accepted
- alu_a, alu_b  out  8  to ALU INPUTA/INPUTB
- alu_op  out  4  to ALU OP (op_mne codes)
- alu_out  in  8  from ALU OUT
- busy  out  1  high from the first pass through DONE
- done  out  1  one-cycle pulse; result/carry_out valid
- result  out  16  held until the next accepted start
- carry_out  out  1  16-bit carry/borrow/shift-out; 0 for logical ops and MOV
- zero  out  1  combinational (result == 0)

## Operation
- FSM states: IDLE, P1, P2, P3, DONE. IDLE→P1 on start. P1→P2. P2→P3 for ADD/SUB/SHL1/SHR1, P2→DONE for AND/OR/XOR/MOV. P3→DONE. DONE→IDLE.
- Each pass drives the ALU combinationally from registered operands. alu_out is captured on the edge that ends the pass.
- W_ADD:
  - P1 KADD(a_lo, b_lo); c = (out < a_lo).
  - P2 KADD(a_hi, b_hi); c_hi = (out < a_hi).
  - P3 KADD(hi, {7'b0, c}); c_fix = c & (out == 0).
  - carry_out = c_hi | c_fix.
- W_SUB: same sequence with KSUB; borrow = (a_lo < b_lo), b_hi = (a_hi < b_hi), b_fix = borrow & (hi == 0).
- W_SHL1:
  - P1 KLSH(a_lo, 1); c = a_lo[7].
  - P2 KLSH(a_hi, 1).
  - P3 kor(hi, {7'b0, c}).
  - carry_out = a_hi[7].
- W_SHR1:
  - P1 KRSH(a_hi, 1); c = a_hi[0].
  - P2 KRSH(a_lo, 1).
  - P3 kor(lo, {c, 7'b0}).
  - carry_out = a_lo[0].
- AND/OR/XOR: P1 low byte, P2 high byte with KAND / kor / KXOR.
- MOV: KLOA, so result = a.
- result and carry_out update only on the edge leaving the last pass. They hold through DONE, IDLE and the next operation until that operation's last pass.
- IDLE and DONE drive alu_a = alu_b = 0, alu_op = KAND.
- start in any state other than IDLE is ignored; no queueing. start in IDLE while Reset is high is ignored.
- Reset mid-operation: next state IDLE, no done pulse, result and carry_out cleared.

## Timing
- Reset values: busy 0, done 0, result 0x0000, carry_out 0, zero 1, state IDLE.
- Edge 0 accepts start, so P1 is the cycle after edge 0.
- ADD/SUB/SHL1/SHR1: done high in cycle 4 after edge 0 (P1, P2, P3, DONE). AND/OR/XOR/MOV: done high in cycle 3.
- Earliest back-to-back start: the cycle after DONE (IDLE). Throughput is one op per 5 cycles (arith/shift) or 4 cycles (logical/MOV).
- The ALU path is purely combinational within one cycle; no multicycle constraint.

## Structure
- Shared package definitions:
  - wide_op_e typedef (3-bit enum above).
  - wide_state_e typedef.
  - the existing op_mne ALU codes (KADD, KSUB, KLSH, KRSH, KAND, kor, KXOR, KLOA) are referenced, not redefined.
- Single module, no sub-modules. The ALU is instantiated by the parent; the bench instantiates both.

## Test plan
- Reset then idle: result 0x0000, zero 1, busy 0, alu_op KAND with zero inputs.
- W_ADD 0x00FF + 0x0001 → result 0x0100, carry_out 0; done exactly 4 cycles after the start edge. W_ADD 0xFFFF + 0x0001 → 0x0000, carry_out 1, zero 1.
- W_SUB 0x0100 − 0x0001 → 0x00FF, carry_out 0. W_SUB 0x0000 − 0x0001 → 0xFFFF, carry_out 1.
- W_SHL1 a = 0x80C0 → 0x0180, carry_out 1. W_SHR1 a = 0x0101 → 0x0080, carry_out 1.
- W_XOR 0xA5A5 ^ 0x0FF0 → 0xAA55, carry_out 0, done 3 cycles after start. A second start pulsed during P1 and during DONE is ignored: exactly one done, and result is unchanged by the stray start.
- Reset asserted in P2 of a W_ADD → IDLE next edge, no done, result 0x0000. A fresh W_MOV a = 0x1234 then yields 0x1234.
